// File: rtl/csi_frame_wr_sched_if.sv
// AXI write-address and write-response channel bundle for the CSI frame write scheduler.
interface csi_frame_wr_sched_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic                  bready;

  modport master (
    output awaddr, awlen, awvalid, bready,
    input  awready, bvalid, bresp
  );

  modport slave (
    input  awaddr, awlen, awvalid, bready,
    output awready, bvalid, bresp
  );
endinterface

// File: rtl/csi_frame_wr_sched.sv
// Frame-capture write-burst scheduler: issues AW bursts from the pixel FIFO level into
// rotating frame buffers, splits at 4 KB, tracks W/B and pulses an interrupt per frame.
module csi_frame_wr_sched #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_BUFFERS     = 2,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEVEL_WIDTH     = 10
) (
  input  logic                              axi_clk_i,
  input  logic                              axi_reset_i,
  input  logic                              enable_i,
  input  logic [NUM_BUFFERS*ADDR_WIDTH-1:0] buf_base_addr_i,
  input  logic                              frame_start_i,
  input  logic                              frame_end_i,
  input  logic [LEVEL_WIDTH-1:0]            fifo_level_i,
  input  logic                              w_beat_i,
  csi_frame_wr_sched_if.master              m_axi_csi,
  output logic [1:0]                        active_buf_o,
  output logic                              busy_o,
  output logic                              err_o,
  output logic                              frame_wr_done_intr_o
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int OW     = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_STREAM   = 3'd2,
    S_FLUSH    = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [7:0]              awlen_q, awlen_d;
  logic                    awvalid_q, awvalid_d;
  logic                    bready_q;
  logic [1:0]              buf_q, buf_d;
  logic                    busy_q;
  logic                    err_q, err_d;
  logic                    intr_q;
  logic [LEVEL_WIDTH-1:0]  committed_q, committed_d;
  logic [OW-1:0]           outst_q, outst_d;

  logic                    aw_hs_s, b_hs_s, can_issue_s, issue_s;
  logic [LEVEL_WIDTH-1:0]  avail_s;
  logic [15:0]             avail16_s, bound_s, full_s, len_s;
  logic [ADDR_WIDTH-1:0]   base_s, step_s;

  assign aw_hs_s     = awvalid_q & m_axi_csi.awready;
  assign b_hs_s      = m_axi_csi.bvalid & bready_q;
  assign avail_s     = fifo_level_i - committed_q;
  assign avail16_s   = 16'(avail_s);
  // awaddr_q always holds the next burst address, so the 4 KB bound is taken from it
  assign bound_s     = 16'((13'h1000 - {1'b0, awaddr_q[11:0]}) >> BSHIFT);
  assign full_s      = (bound_s < 16'(MAX_BURST_LEN)) ? bound_s : 16'(MAX_BURST_LEN);
  assign len_s       = ((state_q == S_FLUSH) && (avail16_s < full_s)) ? avail16_s : full_s;
  assign step_s      = (ADDR_WIDTH'(awlen_q) + ADDR_WIDTH'(1)) << BSHIFT;
  assign base_s      = buf_base_addr_i[int'(buf_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign can_issue_s = !awvalid_q && (outst_q < OW'(MAX_OUTSTANDING));

  // next-state, burst issue and bookkeeping
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    awlen_d     = awlen_q;
    awvalid_d   = awvalid_q;
    buf_d       = buf_q;
    err_d       = err_q;
    issue_s     = 1'b0;
    committed_d = committed_q
                + (aw_hs_s ? (LEVEL_WIDTH'(awlen_q) + LEVEL_WIDTH'(1)) : {LEVEL_WIDTH{1'b0}})
                - LEVEL_WIDTH'(w_beat_i);
    case ({aw_hs_s, b_hs_s})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
    if (aw_hs_s) begin
      awvalid_d = 1'b0;
      awaddr_d  = awaddr_q + step_s;
    end else begin
      awvalid_d = awvalid_q;
    end
    if (b_hs_s && (m_axi_csi.bresp != 2'b00)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_WAIT_SOF;
        else          state_d = S_IDLE;
      end
      S_WAIT_SOF: begin
        if (frame_start_i) begin
          awaddr_d = base_s;
          err_d    = 1'b0;
          state_d  = S_STREAM;
        end else if (!enable_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_SOF;
        end
      end
      S_STREAM: begin
        issue_s = can_issue_s && (avail16_s >= full_s);
        if (frame_end_i) state_d = S_FLUSH;
        else             state_d = S_STREAM;
      end
      S_FLUSH: begin
        issue_s = can_issue_s && (avail_s != {LEVEL_WIDTH{1'b0}});
        if ((avail_s == {LEVEL_WIDTH{1'b0}}) && !awvalid_q) state_d = S_DRAIN;
        else                                                 state_d = S_FLUSH;
      end
      S_DRAIN: begin
        if ((outst_q == OW'(0)) && (committed_q == {LEVEL_WIDTH{1'b0}})) state_d = S_DONE;
        else                                                            state_d = S_DRAIN;
      end
      S_DONE: begin
        buf_d   = (buf_q == 2'(NUM_BUFFERS - 1)) ? 2'd0 : buf_q + 2'd1;
        state_d = enable_i ? S_WAIT_SOF : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (issue_s) begin
      awvalid_d = 1'b1;
      awlen_d   = 8'(len_s - 16'd1);
    end else begin
      awlen_d = awlen_d;
    end
  end

  // state and registered outputs
  always_ff @(posedge axi_clk_i) begin
    if (axi_reset_i) begin
      state_q     <= S_IDLE;
      awaddr_q    <= {ADDR_WIDTH{1'b0}};
      awlen_q     <= 8'd0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      buf_q       <= 2'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      intr_q      <= 1'b0;
      committed_q <= {LEVEL_WIDTH{1'b0}};
      outst_q     <= OW'(0);
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
      awvalid_q   <= awvalid_d;
      bready_q    <= 1'b1;
      buf_q       <= buf_d;
      busy_q      <= (state_d != S_IDLE);
      err_q       <= err_d;
      intr_q      <= (state_d == S_DONE);
      committed_q <= committed_d;
      outst_q     <= outst_d;
    end
  end

  assign m_axi_csi.awaddr  = awaddr_q;
  assign m_axi_csi.awlen   = awlen_q;
  assign m_axi_csi.awvalid = awvalid_q;
  assign m_axi_csi.bready  = bready_q;
  assign active_buf_o         = buf_q;
  assign busy_o               = busy_q;
  assign err_o                = err_q;
  assign frame_wr_done_intr_o = intr_q;
endmodule

// File: doc/csi_frame_wr_sched.md
Name: csi_frame_wr_sched

Overview:
Write-burst scheduler for the CSI frame-capture path: decides when and where the AXI master writes pixel data to memory. Watches the pixel FIFO fill level and issues AW-channel bursts into a rotating set of frame buffers, splitting bursts at 4 KB boundaries. Tracks W beats and B responses, and raises frame_wr_done_intr_o once every write of a frame is acknowledged. Sits between the AXI-lite register file (base addresses, enable) and the AXI master AW/B channels; the W-channel data mover stays external.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; BYTES = DATA_WIDTH/8
NUM_BUFFERS, 2, frame buffers in rotation (1..4)
MAX_BURST_LEN, 16, maximum beats per burst (1..256)
MAX_OUTSTANDING, 4, maximum AW issued without a B response
LEVEL_WIDTH, 10, width of the FIFO level and committed-beat counters

Ports:
axi_clk_i  in  1  clock
axi_reset_i  in  1  synchronous reset, active-high
enable_i  in  1  capture enable (register file)
buf_base_addr_i  in  NUM_BUFFERS*ADDR_WIDTH  buffer base addresses, BYTES-aligned; buffer k occupies slice k
frame_start_i  in  1  SOF pulse, already synchronised to axi_clk_i
frame_end_i  in  1  EOF pulse; all frame data is already in the FIFO
fifo_level_i  in  LEVEL_WIDTH  beats currently held in the pixel FIFO
w_beat_i  in  1  one W beat accepted (wvalid & wready)
m_axi_csi_awaddr_o  out  ADDR_WIDTH  burst address
m_axi_csi_awlen_o  out  8  beats-1
m_axi_csi_awvalid_o  out  1  AW valid
m_axi_csi_awready_i  in  1  AW ready
m_axi_csi_bvalid_i  in  1  B valid
m_axi_csi_bresp_i  in  2  B response
m_axi_csi_bready_o  out  1  B ready
active_buf_o  out  2  index of the buffer being written
busy_o  out  1  high in every state except IDLE
err_o  out  1  sticky: a B response other than OKAY was received
frame_wr_done_intr_o  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset values: awvalid=0, awaddr=0, awlen=0, bready=0, active_buf=0, busy=0, err=0, intr=0.
- Internal counters and state are cleared by reset: outstanding, committed, buffer index, FSM=IDLE. Reset mid-frame abandons all in-flight transactions.
- bready_o = 1 from the first cycle after reset release.
- avail = fifo_level_i - committed. committed counts beats claimed by issued AW but not yet sent on W.
- committed: +(awlen+1) on an AW handshake; -1 on w_beat_i; both in the same cycle → net sum.
- outstanding: +1 on an AW handshake; -1 on a B handshake; both in the same cycle → unchanged. Never exceeds MAX_OUTSTANDING.
- bound4k = (4096 - awaddr[11:0]) / BYTES.
- Burst length = min(MAX_BURST_LEN, bound4k, avail in FLUSH).
- FSM:
  - IDLE: enable_i=1 → WAIT_SOF.
  - WAIT_SOF: frame_start_i → load addr = base[active_buf] and clear err → STREAM. enable_i=0 → IDLE.
  - STREAM: issue a burst when avail ≥ min(MAX_BURST_LEN, bound4k), outstanding < MAX_OUTSTANDING, and no AW is pending. frame_end_i (latched, even while awvalid is high) → FLUSH.
  - FLUSH: issue a partial burst while avail > 0. Once avail = 0 with no AW pending → DRAIN.
  - DRAIN: outstanding = 0 and committed = 0 → DONE.
  - DONE: intr high for exactly one cycle; active_buf ← (active_buf+1) mod NUM_BUFFERS. Next state is WAIT_SOF if enable_i, else IDLE.
- AW issue:
  - awvalid rises the cycle after the issue condition is true (registered).
  - awaddr and awlen are held stable until awready.
  - Address advances by (awlen+1)*BYTES on the handshake.
  - At most one AW is in flight (awvalid high) at a time.
- A burst is never split across a 4 KB boundary; a burst ending exactly on a boundary is legal.
- enable_i dropping mid-frame: the current frame completes normally, then the FSM goes to IDLE.
- frame_start_i outside WAIT_SOF: ignored.
- A frame with zero data (frame_end_i with avail=0): goes straight through FLUSH and DRAIN; intr still pulses.
- B responses are counted regardless of bresp. Any bresp≠0 sets err_o, which holds until the next frame start or reset.

Test Plan:
- Base0=0x1000_0000, MAX_BURST_LEN=16. FIFO level steps to 16, W beats returned, 64 beats total, then EOF, B responses → exactly 4 AW (awlen=15) at 0x1000_0000/40/80/C0; intr pulses once; active_buf=1.
- Base0=0x1000_0FF0, 16 beats available → first AW awlen=3 at 0x1000_0FF0; next AW at 0x1000_1000 awlen=15 once 16 more beats are available.
- EOF with 5 residual beats → FLUSH issues awlen=4. Zero-data frame → no AW, intr still pulses.
- awready held low for 10 cycles, B delayed until 4 AW have issued → awaddr/awlen stable throughout; no 5th AW until a B arrives. Simultaneous AW and B handshake leaves outstanding unchanged.
- bresp=2'b10 on the second burst → err_o=1 and stays high; frame still completes; err_o clears on the next SOF.
- axi_reset_i asserted mid-STREAM → next cycle all outputs at reset values, FSM in IDLE, active_buf=0.
